mem_dump_unit: RTL and testbench
================================

Name: mem_dump_unit

Overview:
- Debug-side reader that sits directly upstream of the BIP data memory. It drives the memory's read strobe and address, and consumes the registered read data.
- On a start request it walks data memory from address 0 to DUMP_WORDS-1.
- Each word is serialised MSB-byte-first into a byte stream for the UART transmitter, using a start/done handshake per byte.
- Used after program halt to dump memory contents to the host.

Parameters:
- ADDRESS_BITS, 11, width of the data memory address.
- DATA_BITS, 16, width of a memory word; must be a multiple of 8.
- DUMP_WORDS, 2048, number of words dumped, from address 0 to DUMP_WORDS-1; must be in the range 1 to 2**ADDRESS_BITS.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  dump request; sampled only in IDLE.
- o_mem_read  out  1  read strobe to data memory.
- o_mem_address  out  ADDRESS_BITS  word address to data memory.
- i_mem_data  in  DATA_BITS  registered read data from memory; valid one cycle after the strobe.
- o_tx_data  out  8  byte presented to the UART transmitter.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- i_tx_done  in  1  pulse from the transmitter when the byte has been sent.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - o_mem_read=0, o_mem_address=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0.
  - Internal word register and byte index cleared.
  - Reset overrides any state, including mid-byte or mid-read; no further tx_start is issued.
- States: IDLE, READ, LATCH, SEND, WAIT_TX, (CHK), DONE.
- IDLE: when i_start=1, set address=0 and go to READ. Otherwise stay.
- READ: o_mem_read=1 for exactly one cycle with o_mem_address=current address, then go to LATCH.
- LATCH: capture i_mem_data into the word register (memory has 1-cycle read latency), set byte index=0, go to SEND.
- SEND:
  - o_tx_data = byte[index], where index 0 is the most-significant byte.
  - o_tx_start=1 for this cycle only; go to WAIT_TX.
- WAIT_TX:
  - o_tx_data is held stable and o_tx_start=0.
  - Remain in WAIT_TX indefinitely until i_tx_done=1.
  - When i_tx_done=1:
    - If more bytes remain in the word: increment index, go to SEND.
    - Else if address == DUMP_WORDS-1: go to CHK if the feature is enabled, otherwise DONE.
    - Else: increment address, go to READ.
- DONE: o_done=1 for one cycle, then go to IDLE. The address stays at its final value until the next start.
- Timing:
  - Minimum per word: 2 cycles (READ + LATCH), plus per byte 1 cycle (SEND) + cycles spent in WAIT_TX.
  - First o_tx_start is asserted 3 cycles after i_start is sampled.
- Boundaries:
  - i_start outside IDLE is ignored.
  - i_tx_done outside WAIT_TX is ignored.
  - i_tx_done arriving in the same cycle as SEND is ignored; the block waits in WAIT_TX for the next pulse.
  - The address never wraps: the last read is DUMP_WORDS-1.
  - DUMP_WORDS=1 dumps only address 0.
  - The block never writes memory; the top level muxes the memory address/read between CPU and dump unit using o_busy.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- When defined:
  - An 8-bit running XOR of every transmitted data byte is kept; it is cleared when i_start is accepted.
  - After the last word, state CHK presents the XOR on o_tx_data with a SEND/WAIT_TX-style handshake, then goes to DONE.
  - The byte count per dump becomes DUMP_WORDS*DATA_BITS/8 + 1.
- When undefined:
  - The CHK state and checksum register are absent; the last word goes directly to DONE.

Test Plan:
- Basic dump:
  - Setup: DUMP_WORDS=2, mem[0]=0xA5C3, mem[1]=0x1234, transmitter returns i_tx_done 1 cycle after each o_tx_start; pulse i_start.
  - Required: bytes 0xA5, 0xC3, 0x12, 0x34 in order; exactly 4 o_tx_start pulses; o_mem_read pulsed with address 0 then 1; o_done single pulse; o_busy falls with return to IDLE.
- Checksum (MEM_DUMP_CHECKSUM_EN defined):
  - Same stimulus as the basic dump.
  - Required: a fifth byte 0x40; o_done follows its i_tx_done.
- Transmitter stall:
  - Hold i_tx_done=0 for 100 cycles after the first byte.
  - Required: single o_tx_start pulse; o_tx_data stays 0xA5; no memory read during the stall; normal progress after i_tx_done.
- Spurious inputs:
  - Pulse i_start while busy; pulse i_tx_done during READ.
  - Required: sequence unchanged; no second dump; no skipped byte.
- Reset mid-dump:
  - Assert rst during WAIT_TX of the second byte.
  - Required: next cycle all outputs 0 and state IDLE; a fresh i_start restarts from address 0 with byte 0xA5.
- Full size:
  - DUMP_WORDS=2048, mem[i]=i.
  - Required: 4096 bytes; last read address 0x7FF; last bytes 0x07, 0xFF; no read of address 0 after 0x7FF; o_done once.

Source files
------------

// File: rtl/mem_dump_unit.sv
// Walks data memory from address 0 to DUMP_WORDS-1 and sends each word MSB byte first to the UART.
// Optional trailing XOR checksum byte is enabled with `define MEM_DUMP_CHECKSUM_EN.
module mem_dump_unit #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16,
  parameter int DUMP_WORDS   = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  output logic                    o_mem_read,
  output logic [ADDRESS_BITS-1:0] o_mem_address,
  input  logic [DATA_BITS-1:0]    i_mem_data,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int NBYTES = DATA_BITS / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(DUMP_WORDS - 1);
  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NBYTES - 1);

`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_SEND, S_WAIT_TX, S_CHK, S_CHK_WAIT, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_SEND, S_WAIT_TX, S_DONE
  } state_t;
`endif

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0]    r_word;
  logic [IDX_W-1:0]        r_idx;
  logic [7:0]              w_byte;
  logic                    w_last_byte;
  logic                    w_last_word;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]              r_xor;
`endif

  assign w_last_byte   = (r_idx == LAST_IDX);
  assign w_last_word   = (r_addr == LAST_ADDR);
  assign o_mem_address = r_addr;

  // Index 0 selects the most-significant byte of the latched word.
  always_comb begin
    w_byte = 8'(r_word >> (8 * (NBYTES - 1 - int'(r_idx))));
  end

  always_comb begin
    o_tx_data = w_byte;
`ifdef MEM_DUMP_CHECKSUM_EN
    if (r_state == S_CHK || r_state == S_CHK_WAIT) o_tx_data = r_xor;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_mem_read = 1'b0;
    o_tx_start = 1'b0;
    o_done     = 1'b0;
    o_busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_READ;
      S_READ: begin
        o_mem_read = 1'b1;
        w_next     = S_LATCH;
      end
      S_LATCH: w_next = S_SEND;
      S_SEND: begin
        o_tx_start = 1'b1;
        w_next     = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (!w_last_byte)      w_next = S_SEND;
          else if (!w_last_word) w_next = S_READ;
`ifdef MEM_DUMP_CHECKSUM_EN
          else                   w_next = S_CHK;
`else
          else                   w_next = S_DONE;
`endif
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CHK: begin
        o_tx_start = 1'b1;
        w_next     = S_CHK_WAIT;
      end
      S_CHK_WAIT: if (i_tx_done) w_next = S_DONE;
`endif
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_word <= '0;
      r_idx  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      r_xor  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            r_xor  <= '0;
`endif
          end
        end
        S_LATCH: begin
          r_word <= i_mem_data;
          r_idx  <= '0;
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        S_SEND: r_xor <= r_xor ^ w_byte;
`endif
        S_WAIT_TX: begin
          if (i_tx_done) begin
            if (!w_last_byte)      r_idx  <= r_idx + IDX_W'(1);
            else if (!w_last_word) r_addr <= r_addr + ADDRESS_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Scoreboard bench: dut_a dumps a 2-word memory, dut_b dumps 2048 words with mem[i]=i.
module tb_mem_dump_unit;

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int NB_A = 5;
  localparam int NB_B = 4097;
`else
  localparam int NB_A = 4;
  localparam int NB_B = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_start, b_start;
  logic        a_rd, b_rd;
  logic [10:0] a_addr, b_addr;
  logic [15:0] a_mdata, b_mdata;
  logic [7:0]  a_txd, b_txd;
  logic        a_txs, b_txs;
  logic        a_done_agent, a_spur, a_txdone, b_txdone;
  logic        a_busy, b_busy, a_dn, b_dn;

  int n_tests = 0;
  int n_fail  = 0;
  int a_starts = 0, a_dones = 0, b_starts = 0, b_dones = 0, b_reads = 0;
  int a_pend = 0, b_pend = 0;
  bit a_stall_first = 1'b0;
  logic [10:0] b_last_addr = '0;
  logic [7:0]  a_exp_b[$];
  logic [7:0]  b_exp_b[$];
  logic [10:0] a_exp_a[$];
  logic [10:0] b_exp_a[$];

  assign a_txdone = a_done_agent | a_spur;

  always #5 clk = ~clk;

  mem_dump_unit #(.ADDRESS_BITS(11), .DATA_BITS(16), .DUMP_WORDS(2)) dut_a (
    .clk(clk), .rst(rst), .i_start(a_start),
    .o_mem_read(a_rd), .o_mem_address(a_addr), .i_mem_data(a_mdata),
    .o_tx_data(a_txd), .o_tx_start(a_txs), .i_tx_done(a_txdone),
    .o_busy(a_busy), .o_done(a_dn)
  );

  mem_dump_unit #(.ADDRESS_BITS(11), .DATA_BITS(16), .DUMP_WORDS(2048)) dut_b (
    .clk(clk), .rst(rst), .i_start(b_start),
    .o_mem_read(b_rd), .o_mem_address(b_addr), .i_mem_data(b_mdata),
    .o_tx_data(b_txd), .o_tx_start(b_txs), .i_tx_done(b_txdone),
    .o_busy(b_busy), .o_done(b_dn)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_a(input logic [10:0] addr);
    case (addr)
      11'd0:   return 16'hA5C3;
      11'd1:   return 16'h1234;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push_a();
    logic [15:0] w;
    logic [7:0]  x;
    x = 8'h00;
    for (int i = 0; i < 2; i++) begin
      w = mem_a(11'(i));
      a_exp_a.push_back(11'(i));
      a_exp_b.push_back(w[15:8]);
      a_exp_b.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    a_exp_b.push_back(x);
`endif
  endtask

  task automatic push_b();
    logic [15:0] w;
    logic [7:0]  x;
    x = 8'h00;
    for (int i = 0; i < 2048; i++) begin
      w = 16'(i);
      b_exp_a.push_back(11'(i));
      b_exp_b.push_back(w[15:8]);
      b_exp_b.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    b_exp_b.push_back(x);
`endif
  endtask

  // Memory and transmitter models; act on the falling edge, away from the DUT's edge.
  initial begin
    a_done_agent = 1'b0;
    b_txdone     = 1'b0;
    a_mdata      = '0;
    b_mdata      = '0;
    forever begin
      @(negedge clk);
      a_done_agent = 1'b0;
      if (a_pend > 0) begin
        a_pend--;
        if (a_pend == 0) a_done_agent = 1'b1;
      end
      if (a_rd) begin
        a_mdata = mem_a(a_addr);
        if (a_exp_a.size() == 0) check("a_extra_read", 32'(a_addr), 32'hFFFF);
        else check("a_rd_addr", 32'(a_addr), 32'(a_exp_a.pop_front()));
      end
      if (a_txs) begin
        a_starts++;
        if (a_exp_b.size() == 0) check("a_extra_byte", 32'(a_txd), 32'hFFFF);
        else check("a_byte", 32'(a_txd), 32'(a_exp_b.pop_front()));
        a_pend = a_stall_first ? 101 : 1;
        a_stall_first = 1'b0;
      end
      if (a_dn) a_dones++;

      b_txdone = 1'b0;
      if (b_pend > 0) begin
        b_pend--;
        if (b_pend == 0) b_txdone = 1'b1;
      end
      if (b_rd) begin
        b_mdata = 16'(b_addr);
        b_reads++;
        b_last_addr = b_addr;
        if (b_exp_a.size() == 0) check("b_extra_read", 32'(b_addr), 32'hFFFF);
        else check("b_rd_addr", 32'(b_addr), 32'(b_exp_a.pop_front()));
      end
      if (b_txs) begin
        b_starts++;
        if (b_exp_b.size() == 0) check("b_extra_byte", 32'(b_txd), 32'hFFFF);
        else check("b_byte", 32'(b_txd), 32'(b_exp_b.pop_front()));
        b_pend = 1;
      end
      if (b_dn) b_dones++;
    end
  end

  task automatic wait_done(input int k, input int target, input int limit);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < limit && !hit; c++) begin
      @(posedge clk); #1;
      hit = ((k == 0) ? a_dones : b_dones) >= target;
    end
    if (!hit) check("timeout_done", 32'(k), 32'hFFFF);
  endtask

  task automatic wait_a_starts(input int target, input int limit);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < limit && !hit; c++) begin
      @(posedge clk); #1;
      hit = (a_starts >= target);
    end
    if (!hit) check("timeout_start", 32'(a_starts), 32'(target));
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_rd"},    32'(a_rd),   32'd0);
    check({tag, "_addr"},  32'(a_addr), 32'd0);
    check({tag, "_txd"},   32'(a_txd),  32'd0);
    check({tag, "_txs"},   32'(a_txs),  32'd0);
    check({tag, "_busy"},  32'(a_busy), 32'd0);
    check({tag, "_done"},  32'(a_dn),   32'd0);
  endtask

  initial begin
    int base_s, base_d, viol;
    bit hit;
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_spur = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_a("reset_a");
    check("reset_b_busy", 32'(b_busy), 32'd0);
    check("reset_b_txs",  32'(b_txs),  32'd0);

    // Basic dump with first-byte latency
    push_a();
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    check("lat_read", 32'(a_rd), 32'd1);
    check("lat_addr0", 32'(a_addr), 32'd0);
    @(posedge clk); #1;
    check("lat_latch_nostart", 32'(a_txs), 32'd0);
    @(posedge clk); #1;
    check("lat_first_start", 32'(a_txs), 32'd1);
    check("lat_first_byte", 32'(a_txd), 32'hA5);
    wait_done(0, 1, 200);
    check("basic_busy_low", 32'(a_busy), 32'd0);
    check("basic_done_pulse", 32'(a_dn), 32'd0);
    check("basic_nbytes", 32'(a_starts), 32'(NB_A));
    check("basic_sb_empty", 32'(a_exp_b.size()), 32'd0);

    // Transmitter stall after first byte
    base_s = a_starts; base_d = a_dones;
    a_stall_first = 1'b1;
    push_a();
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    wait_a_starts(base_s + 1, 20);
    viol = 0;
    for (int c = 0; c < 95; c++) begin
      if (a_txd !== 8'hA5 || a_rd !== 1'b0 || a_txs !== 1'b0 || a_busy !== 1'b1) viol++;
      @(posedge clk); #1;
    end
    check("stall_violations", 32'(viol), 32'd0);
    check("stall_one_start", 32'(a_starts), 32'(base_s + 1));
    wait_done(0, base_d + 1, 300);
    check("stall_nbytes", 32'(a_starts - base_s), 32'(NB_A));

    // Spurious i_start / i_tx_done
    base_s = a_starts; base_d = a_dones;
    push_a();
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (a_txs === 1'b1) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("spur_saw_send", 32'(hit), 32'd1);
    a_spur = 1'b1;
    @(posedge clk); #1 a_spur = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (a_rd === 1'b1 && a_addr === 11'd1) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("spur_saw_read1", 32'(hit), 32'd1);
    a_spur = 1'b1; a_start = 1'b1;
    @(posedge clk); #1 begin a_spur = 1'b0; a_start = 1'b0; end
    wait_done(0, base_d + 1, 200);
    repeat (20) @(posedge clk);
    #1;
    check("spur_idle", 32'(a_busy), 32'd0);
    check("spur_one_done", 32'(a_dones), 32'(base_d + 1));
    check("spur_nbytes", 32'(a_starts - base_s), 32'(NB_A));

    // Reset during WAIT_TX of second byte
    base_s = a_starts; base_d = a_dones;
    push_a();
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    wait_a_starts(base_s + 2, 30);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_a("midrst");
    rst = 1'b0;
    a_exp_b.delete();
    a_exp_a.delete();
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_start", 32'(a_starts), 32'(base_s + 2));
    check("midrst_no_done", 32'(a_dones), 32'(base_d));
    push_a();
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    check("restart_addr0", 32'(a_addr), 32'd0);
    wait_done(0, base_d + 1, 200);
    check("restart_nbytes", 32'(a_starts - base_s - 2), 32'(NB_A));

    // Full-size dump
    push_b();
    b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    wait_done(1, 1, 30000);
    repeat (5) @(posedge clk);
    #1;
    check("full_nbytes", 32'(b_starts), 32'(NB_B));
    check("full_nreads", 32'(b_reads), 32'd2048);
    check("full_last_addr", 32'(b_last_addr), 32'h7FF);
    check("full_one_done", 32'(b_dones), 32'd1);
    check("full_sb_empty", 32'(b_exp_b.size()), 32'd0);
    check("full_busy_low", 32'(b_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
